// File: rtl/gearbox_fifo_pkg.sv
// Shared width helpers for the gearbox FIFO: clog2 and count/pointer width derivation.
package gearbox_fifo_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Count must represent 0..NUM_REG inclusive.
    function automatic int cnt_w(input int num_reg);
        return clog2(num_reg + 1);
    endfunction

    function automatic int ptr_w(input int num_reg);
        return (num_reg > 1) ? clog2(num_reg) : 1;
    endfunction

endpackage

// File: rtl/gearbox_fifo_mem.sv
// Word-addressed storage: PAR_WRITE-word write and PAR_READ-word read at a base slot,
// with slot indices wrapping modulo NUM_REG.
module fifo_mem #(
    parameter int NUM_BIT   = 4,
    parameter int NUM_REG   = 4,
    parameter int PAR_WRITE = 2,
    parameter int PAR_READ  = 1,
    parameter int PTR_W     = 2
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [PTR_W-1:0]                   wptr,
    input  logic [PAR_WRITE-1:0][NUM_BIT-1:0]  wdata,
    input  logic [PTR_W-1:0]                   rptr,
    output logic [PAR_READ-1:0][NUM_BIT-1:0]   rdata
);

    logic [NUM_REG-1:0][NUM_BIT-1:0] mem;

    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base, input int off);
        return PTR_W'((int'(base) + off) % NUM_REG);
    endfunction

    // No reset on storage: stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < PAR_WRITE; i++) mem[slot(wptr, i)] <= wdata[i];
        end
    end

    for (genvar g = 0; g < PAR_READ; g++) begin : g_rd
        assign rdata[g] = mem[slot(rptr, g)];
    end

endmodule

// File: rtl/gearbox_fifo.sv
// Width-converting FIFO: PAR_WRITE words in, PAR_READ words out, registered read data.
// Optional sticky overflow/underflow outputs under GEARBOX_FIFO_ERR_FLAGS_EN.
module gearbox_fifo
    import gearbox_fifo_pkg::*;
#(
    parameter int NUM_BIT   = 4,
    parameter int NUM_REG   = 4,
    parameter int PAR_WRITE = 2,
    parameter int PAR_READ  = 1,
    parameter int AF_TH     = NUM_REG - 1,
    parameter int AE_TH     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_en,
    input  logic                          read_en,
    input  logic [PAR_WRITE*NUM_BIT-1:0]  din,
    output logic [PAR_READ*NUM_BIT-1:0]   dout,
    output logic                          valid,
    output logic                          ready,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_w(NUM_REG)-1:0]     count
`ifdef GEARBOX_FIFO_ERR_FLAGS_EN
    ,
    output logic                          overflow,
    output logic                          underflow
`endif
);

    localparam int CNT_W = cnt_w(NUM_REG);
    localparam int PTR_W = ptr_w(NUM_REG);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(NUM_REG);
    localparam logic [CNT_W-1:0] C_WTH = CNT_W'(NUM_REG - PAR_WRITE);
    localparam logic [CNT_W-1:0] C_PW  = CNT_W'(PAR_WRITE);
    localparam logic [CNT_W-1:0] C_PR  = CNT_W'(PAR_READ);
    localparam logic [CNT_W-1:0] C_AF  = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] C_AE  = CNT_W'(AE_TH);
    localparam logic [PTR_W-1:0] WSTEP = PTR_W'(PAR_WRITE % NUM_REG);
    localparam logic [PTR_W-1:0] RSTEP = PTR_W'(PAR_READ % NUM_REG);

    logic [PTR_W-1:0]              wptr, rptr;
    logic [PAR_READ*NUM_BIT-1:0]   rd_words;
    logic                          wacc, racc;

    // Status comes only from the registered count, never from the request inputs.
    assign ready        = (count <= C_WTH);
    assign full         = (count == C_MAX);
    assign empty        = (count == '0);
    assign almost_full  = (count >= C_AF);
    assign almost_empty = (count <= C_AE);

    assign wacc = write_en & ready;
    assign racc = read_en & (count >= C_PR);

    fifo_mem #(
        .NUM_BIT  (NUM_BIT),
        .NUM_REG  (NUM_REG),
        .PAR_WRITE(PAR_WRITE),
        .PAR_READ (PAR_READ),
        .PTR_W    (PTR_W)
    ) u_mem (
        .clk  (clk),
        .we   (wacc),
        .wptr (wptr),
        .wdata(din),
        .rptr (rptr),
        .rdata(rd_words)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= racc;
            if (wacc) wptr <= wptr + WSTEP;
            if (racc) begin
                rptr <= rptr + RSTEP;
                dout <= rd_words;
            end
            count <= count + (wacc ? C_PW : '0) - (racc ? C_PR : '0);
        end
    end

`ifdef GEARBOX_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (write_en & ~wacc);
            underflow <= underflow | (read_en & ~racc);
        end
    end
`endif

endmodule

// File: doc/gearbox_fifo.md
GEARBOX_FIFO -- requirements
Module: gearbox_fifo

Interface
REQ-001 SHALL have parameter NUM_BIT, default 4, meaning bits per word.
REQ-002 SHALL have parameter NUM_REG, default 4, meaning depth in words; must be a power of two and at least max(PAR_WRITE, PAR_READ).
REQ-003 SHALL have parameter PAR_WRITE, default 2, meaning words accepted per write.
REQ-004 SHALL have parameter PAR_READ, default 1, meaning words delivered per read.
REQ-005 SHALL have parameter AF_TH, default NUM_REG-1, meaning the almost_full threshold in words.
REQ-006 SHALL have parameter AE_TH, default 1, meaning the almost_empty threshold in words.
REQ-007 Ports SHALL be, in order:
- clk  in  1  clock; one clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- write_en  in  1  write request.
- read_en  in  1  read request.
- din  in  PAR_WRITE*NUM_BIT  write words; word 0 in the LSBs is the oldest.
- dout  out  PAR_READ*NUM_BIT  read words; word 0 in the LSBs is the oldest.
- valid  out  1  dout holds fresh data this cycle.
- ready  out  1  a write is acceptable (free >= PAR_WRITE).
- full  out  1  count == NUM_REG.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- count  out  clog2(NUM_REG+1)  occupancy in words.

Function
REQ-008 A write SHALL be accepted on a rising edge when write_en=1 and ready=1; all PAR_WRITE words are stored at consecutive write-pointer slots.
REQ-009 A read SHALL be accepted on a rising edge when read_en=1 and count >= PAR_READ.
REQ-010 On an accepted read, dout SHALL register the PAR_READ oldest words, and valid SHALL be 1 for exactly the following cycle (latency 1).
REQ-011 When no read is accepted, valid SHALL be 0 and dout SHALL hold its last value.
REQ-012 A write_en with ready=0 SHALL be ignored; storage, pointers and count are unchanged.
REQ-013 A read_en with count < PAR_READ SHALL be ignored.
REQ-014 With write and read requested in the same cycle, both acceptance checks SHALL use the pre-edge count; next count = count + PAR_WRITE*wacc - PAR_READ*racc.
REQ-015 Read and write pointers SHALL advance per word modulo NUM_REG; wrap-around SHALL preserve word order.
REQ-016 ready, full, empty, almost_full, almost_empty and count SHALL be registered or derived only from registered state; none SHALL be combinational from write_en or read_en.

Reset
REQ-017 rst=1 SHALL asynchronously clear pointers and count to 0, set dout=0, valid=0, ready=1, full=0, empty=1, almost_full=0, and almost_empty=1.
REQ-018 Assertion of rst mid-operation SHALL discard all stored words; the first edge after deassertion behaves as operation on an empty FIFO.

Configuration
REQ-019 With macro GEARBOX_FIFO_ERR_FLAGS_EN defined, the block SHALL add outputs overflow and underflow (1 bit each).
- overflow is sticky-set on an ignored write_en.
- underflow is sticky-set on an ignored read_en.
- Both clear only on rst.
REQ-020 Without GEARBOX_FIFO_ERR_FLAGS_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-021 Package gearbox_fifo_pkg SHALL hold the clog2 function and the count/pointer width derivation.
REQ-022 Storage SHALL be a sub-module fifo_mem: an NUM_REG x NUM_BIT register array with PAR_WRITE-word write and PAR_READ-word read at a base pointer with modulo wrap.
REQ-023 Pointer, count and flag control SHALL live in gearbox_fifo.

Verification (defaults NUM_BIT=4, NUM_REG=4, PAR_WRITE=2, PAR_READ=1)
REQ-024 Reset, then write din=8'hB2 -> count=2, empty=0, ready=1; then write 8'h1C -> count=4, full=1, ready=0, almost_full=1.
REQ-025 From full, read 4 times -> dout = 4'h2, 4'hB, 4'hC, 4'h1, each with valid=1 one cycle after acceptance; final count=0, empty=1.
REQ-026 count=2, write_en and read_en together with din=8'h5A -> both accepted, count=3, dout = oldest word.
REQ-027 Six write/read cycles crossing the pointer wrap -> read sequence equals write order, with no loss or duplication.
REQ-028 With GEARBOX_FIFO_ERR_FLAGS_EN defined:
- write at full -> overflow=1 and count unchanged.
- read at empty -> underflow=1 and valid stays 0.
- rst pulse mid-stream -> all flags at reset values, count=0.
